// File: rtl/vu_pkg.sv
// Shared types and helpers for the VU meter chain (level/peak stages and later consumers).
// Latency: n/a (package; scale_mag is purely combinational).
// Backpressure: n/a.
package vu_pkg;

   // Default bar resolution, matches the vga stage data width.
   localparam int LEVEL_W = 8;

   // Peak-hold marker behaviour.
   typedef enum logic [1:0] {
      TRACK = 2'd0,
      HOLD  = 2'd1,
      FALL  = 2'd2
   } peak_state_e;

   // Saturating absolute value of a sign-extended sample, then keep the LEVEL bits just
   // below the sign position. The most negative sample clips to the largest positive value
   // so it lands on full scale instead of wrapping. Valid for sample_w up to 32.
   function automatic logic [31:0] scale_mag(input logic signed [31:0] s,
                                              input int                 sample_w,
                                              input int                 level_w);
      logic signed [31:0] most_neg;
      logic [31:0]        mag;
      most_neg = -(32'sd1 <<< (sample_w - 1));
      if (s == most_neg) begin
         mag = (32'd1 << (sample_w - 1)) - 32'd1;
      end else if (s < 0) begin
         mag = 32'(-s);
      end else begin
         mag = 32'(s);
      end
      return mag >> (sample_w - 1 - level_w);
   endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold marker: captures the new level, holds it for HOLD_FRAMES frames, then falls 1/frame.
// Latency: peak updates on the clock edge that ends the frame_tick cycle.
// Backpressure: none; stepped only by frame_tick.
module vu_peak_hold
   import vu_pkg::*;
#(
   parameter int LEVEL_W     = vu_pkg::LEVEL_W,
   parameter int HOLD_FRAMES = 30
) (
   input  logic               pixel_clock,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic [LEVEL_W-1:0] level_new,
   output logic [LEVEL_W-1:0] peak
);

   localparam int               CNT_W     = $clog2(HOLD_FRAMES + 1);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   peak_state_e        state_q, state_d;
   logic [LEVEL_W-1:0] peak_q, peak_d;
   logic [LEVEL_W-1:0] peak_dec;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

   assign peak_dec = peak_q - 1'b1;

   // Next state: a level at or above the marker always re-captures and restarts the hold;
   // otherwise the current state decides how the marker moves toward the level.
   always_comb begin
      state_d    = state_q;
      peak_d     = peak_q;
      hold_cnt_d = hold_cnt_q;
      if (frame_tick) begin
         if (level_new >= peak_q) begin
            peak_d     = level_new;
            hold_cnt_d = HOLD_INIT;
            state_d    = HOLD;
         end else begin
            case (state_q)
               HOLD: begin
                  hold_cnt_d = hold_cnt_q - CNT_ONE;
                  if (hold_cnt_q == CNT_ONE) begin
                     state_d = FALL;
                  end
               end
               FALL: begin
                  peak_d = (peak_dec > level_new) ? peak_dec : level_new;
                  if (peak_dec <= level_new) begin
                     state_d = TRACK;
                  end
               end
               default: begin
                  peak_d  = level_new;
                  state_d = TRACK;
               end
            endcase
         end
      end
   end

   // State, marker and hold counter registers.
   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         state_q    <= TRACK;
         peak_q     <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         peak_q     <= peak_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign peak = peak_q;

endmodule

// File: rtl/vu_level.sv
// Audio samples -> per-frame bar level (instant attack, linear decay) plus peak-hold marker.
// Latency: sample visible in the window max next cycle; level/peak/level_valid one cycle after frame_tick.
// Backpressure: none; every valid sample is absorbed, outputs hold between ticks.
module vu_level
   import vu_pkg::*;
#(
   parameter int SAMPLE_W    = 16,
   parameter int LEVEL_W     = vu_pkg::LEVEL_W,
   parameter int DECAY_STEP  = 4,
   parameter int HOLD_FRAMES = 30
) (
   input  logic                pixel_clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                sample_valid,
   input  logic                frame_tick,
   output logic [LEVEL_W-1:0]  level,
   output logic [LEVEL_W-1:0]  peak,
   output logic                level_valid
);

   localparam logic [LEVEL_W-1:0] DSTEP = LEVEL_W'(DECAY_STEP);

   logic [LEVEL_W-1:0] smag;
   logic [LEVEL_W-1:0] win_max_q, win_max_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [LEVEL_W-1:0] decayed;
   logic               level_valid_q;

   assign smag = LEVEL_W'(scale_mag(32'(signed'(sample)), SAMPLE_W, LEVEL_W));

   // Window maximum: a sample arriving with the tick opens the next window.
   always_comb begin
      win_max_d = win_max_q;
      if (frame_tick) begin
         win_max_d = sample_valid ? smag : '0;
      end else if (sample_valid && (smag > win_max_q)) begin
         win_max_d = smag;
      end
   end

   // Level: jump up to the window max, otherwise fall by at most DECAY_STEP (floored at 0).
   always_comb begin
      decayed = (level_q > DSTEP) ? (level_q - DSTEP) : '0;
      level_d = level_q;
      if (frame_tick) begin
         if (win_max_q >= level_q) begin
            level_d = win_max_q;
         end else begin
            level_d = (decayed > win_max_q) ? decayed : win_max_q;
         end
      end
   end

   // Window, level and update-strobe registers.
   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         win_max_q     <= '0;
         level_q       <= '0;
         level_valid_q <= 1'b0;
      end else begin
         win_max_q     <= win_max_d;
         level_q       <= level_d;
         level_valid_q <= frame_tick;
      end
   end

   // The marker sees the level being registered this edge so it never drops below it.
   vu_peak_hold #(
      .LEVEL_W     (LEVEL_W),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_peak_hold (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .level_new   (level_d),
      .peak        (peak)
   );

   assign level       = level_q;
   assign level_valid = level_valid_q;

endmodule

// File: tb/tb_vu_level.sv
// Bench for vu_level: directed scenarios plus random samples/ticks against a frame-level model.
// Latency: expected level/peak are queued at each tick and matched when level_valid appears.
// Backpressure: none.
module tb_vu_level;

   localparam int SW = 16;
   localparam int LW = 8;
   localparam int DS = 4;
   localparam int HF = 30;

   logic          pixel_clock = 1'b0;
   logic          reset;
   logic [SW-1:0] sample;
   logic          sample_valid;
   logic          frame_tick;
   logic [LW-1:0] level;
   logic [LW-1:0] peak;
   logic          level_valid;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_lvl_q[$];
   int exp_pk_q[$];

   // Reference state, kept as plain integers per frame.
   int m_win, m_lvl, m_pk, m_since;
   bit m_track;

   always #5 pixel_clock = ~pixel_clock;

   vu_level #(
      .SAMPLE_W    (SW),
      .LEVEL_W     (LW),
      .DECAY_STEP  (DS),
      .HOLD_FRAMES (HF)
   ) dut (
      .pixel_clock  (pixel_clock),
      .reset        (reset),
      .sample       (sample),
      .sample_valid (sample_valid),
      .frame_tick   (frame_tick),
      .level        (level),
      .peak         (peak),
      .level_valid  (level_valid)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // |sample| clipped to full positive scale, divided down to LW bits.
   function automatic int ref_smag(input logic [SW-1:0] s);
      int v, m;
      v = int'(signed'(s));
      m = (v < 0) ? -v : v;
      if (m > (1 << (SW - 1)) - 1) m = (1 << (SW - 1)) - 1;
      return m / (1 << (SW - 1 - LW));
   endfunction

   function automatic void model_reset();
      m_win   = 0;
      m_lvl   = 0;
      m_pk    = 0;
      m_since = 0;
      m_track = 1'b1;
   endfunction

   // One clock cycle of stimulus; on a tick the frame outcome is predicted and queued.
   task automatic step(input logic [SW-1:0] s, input logic v, input logic t);
      @(negedge pixel_clock);
      sample       = s;
      sample_valid = v;
      frame_tick   = t;
      if (t) begin
         int nl;
         nl = (m_win >= m_lvl) ? m_win : max2(m_lvl - DS, m_win);
         m_lvl = nl;
         if (nl >= m_pk) begin
            m_pk    = nl;
            m_since = 0;
            m_track = 1'b0;
         end else if (m_track) begin
            m_pk = nl;
         end else begin
            m_since++;
            if (m_since > HF) begin
               m_pk = max2(m_pk - 1, nl);
               if (m_pk == nl) m_track = 1'b1;
            end
         end
         m_win = v ? ref_smag(s) : 0;
         exp_lvl_q.push_back(m_lvl);
         exp_pk_q.push_back(m_pk);
      end else if (v) begin
         m_win = max2(m_win, ref_smag(s));
      end
   endtask

   // Asserted just after a clock edge so the outputs must clear without another edge.
   task automatic do_reset(input string tag);
      @(posedge pixel_clock);
      #2;
      reset        = 1'b0;
      sample_valid = 1'b0;
      frame_tick   = 1'b0;
      #1;
      check({tag, "_level"}, int'(level), 0);
      check({tag, "_peak"}, int'(peak), 0);
      check({tag, "_valid"}, int'(level_valid), 0);
      model_reset();
      exp_lvl_q.delete();
      exp_pk_q.delete();
      @(negedge pixel_clock);
      @(negedge pixel_clock);
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every level_valid must match the oldest predicted frame.
   always @(negedge pixel_clock) begin
      if (reset && level_valid) begin
         if (exp_lvl_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_valid: got level_valid=1, expected no update at %0t", $time);
         end else begin
            check("sb_level", int'(level), exp_lvl_q.pop_front());
            check("sb_peak", int'(peak), exp_pk_q.pop_front());
            n_tests++;
            if (peak < level) begin
               n_fail++;
               $display("FAIL sb_invariant: got peak=%0d, required >= level=%0d", peak, level);
            end
         end
      end
   end

   initial begin
      reset        = 1'b0;
      sample       = '0;
      sample_valid = 1'b0;
      frame_tick   = 1'b0;
      model_reset();
      #1;
      check("por_level", int'(level), 0);
      check("por_peak", int'(peak), 0);
      check("por_valid", int'(level_valid), 0);
      @(negedge pixel_clock);
      @(negedge pixel_clock);
      reset = 1'b1;

      // Single sample -> 128 on the next tick, one-cycle valid pulse.
      step(16'h4000, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("single_level", int'(level), 128);
      check("single_peak", int'(peak), 128);
      check("single_valid_hi", int'(level_valid), 1);
      step(16'h0000, 1'b0, 1'b0);
      check("single_valid_lo", int'(level_valid), 0);

      // Decay by 4 per frame; peak held for 30 frames then falls by 1.
      for (int i = 1; i <= 40; i++) begin
         step(16'h0000, 1'b0, 1'b1);
         step(16'h0000, 1'b0, 1'b0);
         check("decay_level", int'(level), max2(128 - DS * i, 0));
         check("decay_peak", int'(peak), (i <= HF) ? 128 : 128 - (i - HF));
      end

      // Saturation at both extremes; reset lands mid-hold right after an update.
      step(16'h8000, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("sat_neg_level", int'(level), 255);
      step(16'h0000, 1'b0, 1'b1);
      do_reset("rst_midhold");
      step(16'h7FFF, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("sat_pos_level", int'(level), 255);
      check("sat_pos_peak", int'(peak), 255);

      // Sample in the tick cycle belongs to the next window.
      do_reset("rst_b");
      step(16'h0500, 1'b1, 1'b0);
      step(16'h2000, 1'b1, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("same_cycle_level", int'(level), 10);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("next_window_level", int'(level), 64);

      // Re-capture during hold restarts the 30-frame hold.
      do_reset("rst_c");
      step(16'h4000, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(16'h0000, 1'b0, 1'b1);
      step(16'h6400, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("recap_level", int'(level), 200);
      check("recap_peak", int'(peak), 200);
      for (int i = 1; i <= HF + 1; i++) begin
         step(16'h0000, 1'b0, 1'b1);
         step(16'h0000, 1'b0, 1'b0);
         check("recap_hold_peak", int'(peak), (i <= HF) ? 200 : 199);
      end

      // Random traffic, including back-to-back ticks and quiet stretches.
      for (int i = 0; i < 4000; i++) begin
         logic [SW-1:0] rs;
         logic          rv, rt;
         rs = SW'($urandom);
         if ($urandom_range(0, 3) == 0) rs = SW'($urandom_range(0, 2047));
         rv = (i % 800 < 500) ? ($urandom_range(0, 1) == 1) : 1'b0;
         rt = ($urandom_range(0, 7) == 0);
         step(rs, rv, rt);
         if (i == 2000) do_reset("rst_rand");
      end

      step(16'h0000, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
      check("sb_pending", exp_lvl_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
